bus_master_a: RTL and testbench
===============================

// Module: bus_master_a
// PURPOSE
//  Upstream requester for the clkA shared-bus arbiter. Buffers 64-bit words from a local
//  producer in a small FIFO, raises reqA, waits for the one-cycle gntA pulse, then drives
//  a burst of up to BURST_MAX words onto sharedBus. After the burst it drops reqA.
//  Sits between the local datapath (valid/ready) and the arbiter's reqA/gntA/sharedBus.
// PARAMETERS
//  DATA_W       64  width of in_data and sharedBus
//  FIFO_DEPTH    8  entries in input buffer; power of two, >= 2
//  BURST_MAX     4  max words driven per grant; 1..FIFO_DEPTH
//  GNT_TIMEOUT  32  REQ-state cycles without gntA before abort/retry; must be > 11
// PORTS
//  clkA        in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  in_valid    in   1       producer word valid
//  in_ready    out  1       buffer can accept (= !full)
//  in_data     in   DATA_W  producer word
//  reqA        out  1       bus request to arbiter (registered)
//  gntA        in   1       grant from arbiter, single-cycle pulse
//  sharedBus   out  DATA_W  bus data; 0 when bus_valid=0
//  bus_valid   out  1       sharedBus carries a word this cycle
//  busy        out  1       FSM not in IDLE
//  timeout_err out  1       one-cycle pulse on grant timeout
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (reset=0, async): reqA=0, bus_valid=0, sharedBus=0, busy=0, timeout_err=0,
//   FIFO emptied (fifo_level=0, in_ready=1), FSM=IDLE, counters=0. Mid-burst reset drops
//   the burst; words already driven are lost to no one, undriven words are discarded.
//  Push: in_valid & in_ready at edge -> word stored. Full -> in_ready=0, in_data ignored.
//  FSM (all outputs registered):
//   IDLE    : fifo_level!=0 -> REQ, reqA=1 from next cycle. Else stay, reqA=0.
//   REQ     : reqA=1; wait_cnt increments each cycle. gntA=1 sampled -> XFER, burst_cnt=0.
//             wait_cnt==GNT_TIMEOUT-1 without gntA -> RELEASE, timeout_err=1 for 1 cycle.
//             gntA and timeout same cycle -> grant wins, no error.
//   XFER    : each cycle pop one word: bus_valid=1, sharedBus=word, burst_cnt++.
//             reqA held 1. Leave to RELEASE when burst_cnt reaches BURST_MAX or
//             FIFO becomes empty after this pop. gntA ignored in XFER.
//   RELEASE : exactly 1 cycle, reqA=0, bus_valid=0 (gives arbiter a fresh reqA rising
//             edge on retry) -> IDLE.
//  Latency: push into empty FIFO at edge N -> reqA=1 after edge N+1; gntA high at edge G
//   -> first bus_valid=1 after edge G+1; words leave in FIFO order, back-to-back.
//  Simultaneous push and pop in XFER: both occur, level unchanged; a word pushed during
//   the burst may join it if BURST_MAX not reached.
//  Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH or underflows.
//  busy=1 in REQ/XFER/RELEASE.
// STRUCTURE
//  bus_a_pkg: DATA_W default, state enum {IDLE,REQ,XFER,RELEASE}, burst/timeout widths.
//  Sub-module bus_a_fifo: sync FIFO (push/pop/full/empty/level, async active-low reset).
//  Top holds FSM, wait_cnt, burst_cnt, registered bus outputs.
// TESTING
//  1 reset low mid-XFER -> all outputs 0 same cycle, level=0, in_ready=1 after release.
//  2 push 1 word 0xDEAD_BEEF, gntA pulse 11 cycles after reqA rises -> one bus_valid
//    cycle with sharedBus=0xDEADBEEF, then reqA=0 for 1 cycle, IDLE.
//  3 push 6 words, BURST_MAX=4 -> first grant moves words 0-3, RELEASE, re-REQ,
//    second grant moves words 4-5 in order.
//  4 fill 8 words -> in_ready=0, 9th push ignored; push during pop keeps level at 8.
//  5 never assert gntA -> timeout_err pulse at REQ cycle 32, 1 RELEASE cycle, reqA rises again.
//  6 gntA coincident with timeout cycle -> XFER entered, timeout_err stays 0.

Source files
------------

// File: rtl/bus_a_pkg.sv
// Package: bus_a_pkg
// Purpose : Shared types, default sizes and width helper for the clkA bus
//           master slice (bus_master_a and its input buffer bus_a_fifo).
// Contents:
//   DEF_DATA_W       default width of producer words and sharedBus
//   DEF_FIFO_DEPTH   default input buffer depth (power of two, >= 2)
//   DEF_BURST_MAX    default max words driven per grant
//   DEF_GNT_TIMEOUT  default REQ cycles without a grant before retrying
//   state_t          requester FSM states
//   cnt_w()          width needed to hold 0..max_val
package bus_a_pkg;

    localparam int DEF_DATA_W      = 64;
    localparam int DEF_FIFO_DEPTH  = 8;
    localparam int DEF_BURST_MAX   = 4;
    localparam int DEF_GNT_TIMEOUT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        XFER    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Bits needed to represent every value in 0..max_val (never less than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bus_a_fifo.sv
// Module : bus_a_fifo
// Purpose: Synchronous first-word-fall-through FIFO buffering producer words
//          until the bus master gets a grant. Pushes into a full FIFO and
//          pops from an empty FIFO are ignored, so level never wraps.
// Ports  :
//   clkA   in   clock, rising edge
//   reset  in   asynchronous, active-low reset (empties the FIFO)
//   push   in   write wdata this cycle (ignored when full)
//   wdata  in   DATA_W word to store
//   pop    in   discard the head word this cycle (ignored when empty)
//   rdata  out  head word, valid whenever empty=0
//   full   out  level == DEPTH
//   empty  out  level == 0
//   level  out  current occupancy, 0..DEPTH
module bus_a_fifo
    import bus_a_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic              clkA,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because level and the pointers are reset, and leaving the array out of
    // the reset tree lets it map onto plain registers or RAM.
    always_ff @(posedge clkA) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // increment wraps modulo DEPTH on its own.
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/bus_master_a.sv
// Module : bus_master_a
// Purpose: Upstream requester for the clkA shared-bus arbiter. Buffers
//          producer words, raises reqA, waits for the single-cycle gntA
//          pulse, then drives a burst of up to BURST_MAX words onto
//          sharedBus. A one-cycle RELEASE with reqA=0 follows every burst or
//          grant timeout so the arbiter always sees a fresh reqA rising edge.
// Ports  :
//   clkA        in   clock, rising edge
//   reset       in   asynchronous, active-low reset
//   in_valid    in   producer word valid
//   in_ready    out  buffer can accept (= !full)
//   in_data     in   producer word
//   reqA        out  bus request (registered)
//   gntA        in   grant pulse from arbiter
//   sharedBus   out  bus data, 0 when bus_valid=0 (registered)
//   bus_valid   out  sharedBus carries a word this cycle (registered)
//   busy        out  FSM not in IDLE (registered)
//   timeout_err out  one-cycle pulse on grant timeout (registered)
//   fifo_level  out  current buffer occupancy
module bus_master_a
    import bus_a_pkg::*;
#(
    parameter  int DATA_W      = DEF_DATA_W,
    parameter  int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter  int BURST_MAX   = DEF_BURST_MAX,
    parameter  int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1,
    localparam int BURST_W     = cnt_w(BURST_MAX),
    localparam int WAIT_W      = cnt_w(GNT_TIMEOUT - 1)
) (
    input  logic              clkA,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              reqA,
    input  logic              gntA,
    output logic [DATA_W-1:0] sharedBus,
    output logic              bus_valid,
    output logic              busy,
    output logic              timeout_err,
    output logic [LVL_W-1:0]  fifo_level
);

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [BURST_W-1:0]  burst_cnt;
    logic                burst_done;   // last word of the burst is on the bus

    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_acc;

    logic                pop;
    logic                burst_end;
    logic                timeout_hit;

    assign in_ready = !fifo_full;
    assign push_acc = in_valid && in_ready;

    bus_a_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clkA  (clkA),
        .reset (reset),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        burst_end   = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                // A grant on the timeout cycle wins over the timeout.
                if (gntA) begin
                    next_state = XFER;
                end else if (wait_cnt == WAIT_W'(GNT_TIMEOUT - 1)) begin
                    next_state  = RELEASE;
                    timeout_hit = 1'b1;
                end
            end
            XFER: begin
                // The state stays XFER through the cycle that shows the last
                // word so reqA remains high while the bus is driven.
                if (burst_done || fifo_empty) begin
                    next_state = RELEASE;
                end else begin
                    pop = 1'b1;
                    // The FIFO only drains if no word arrives alongside this
                    // pop; a concurrent push keeps the burst going.
                    burst_end = (burst_cnt == BURST_W'(BURST_MAX - 1)) ||
                                ((fifo_level == LVL_W'(1)) && !push_acc);
                end
            end
            RELEASE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are registered from next_state so they line up with the state
    // the FSM occupies after the edge.
    always_ff @(posedge clkA or negedge reset) begin
        if (!reset) begin
            reqA        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            bus_valid   <= 1'b0;
            sharedBus   <= '0;
            wait_cnt    <= '0;
            burst_cnt   <= '0;
            burst_done  <= 1'b0;
        end else begin
            reqA        <= (next_state == REQ) || (next_state == XFER);
            busy        <= (next_state != IDLE);
            timeout_err <= timeout_hit;
            bus_valid   <= pop;
            sharedBus   <= pop ? fifo_rdata : '0;

            if ((state == REQ) && (next_state == REQ)) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (state != XFER) begin
                burst_cnt  <= '0;
                burst_done <= 1'b0;
            end else begin
                if (pop) begin
                    burst_cnt <= burst_cnt + BURST_W'(1);
                end
                burst_done <= burst_done || burst_end;
            end
        end
    end

endmodule

// File: tb/tb_bus_master_a.sv
// Testbench for bus_master_a: cycle table for a single-word transaction,
// hand-written sequences for bursts, full FIFO, timeout, grant/timeout
// collision and mid-burst reset. A scoreboard queue records every accepted
// producer word and is compared against every word seen on sharedBus.
module tb_bus_master_a;

    localparam int DW = 64;

    logic          clkA;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          reqA;
    logic          gntA;
    logic [DW-1:0] sharedBus;
    logic          bus_valid;
    logic          busy;
    logic          timeout_err;
    logic [3:0]    fifo_level;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_q[$];

    bus_master_a dut (
        .clkA        (clkA),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .reqA        (reqA),
        .gntA        (gntA),
        .sharedBus   (sharedBus),
        .bus_valid   (bus_valid),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_level  (fifo_level)
    );

    initial begin
        clkA = 1'b0;
        forever #5 clkA = ~clkA;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard producer side: record each word the DUT accepts.
    initial begin
        forever begin
            @(posedge clkA);
            if (reset === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
                exp_q.push_back(in_data);
            end
        end
    end

    // Scoreboard consumer side: each bus word must match the oldest accepted
    // word; an idle bus must read as zero.
    initial begin
        forever begin
            @(negedge clkA);
            if (reset === 1'b1) begin
                if (bus_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL bus_word_unexpected: got 0x%0h expected no word at %0t", sharedBus, $time);
                    end else begin
                        check("bus_word_order", sharedBus, exp_q.pop_front());
                    end
                end else begin
                    check("bus_idle_zero", sharedBus, 64'h0);
                end
            end
        end
    end

    typedef struct {
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic          gnt;
        logic          exp_req;
        logic          exp_bv;
        logic [DW-1:0] exp_bus;
        logic          exp_busy;
        logic [3:0]    exp_level;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic g,
                                input logic rq, input logic bv, input logic [DW-1:0] bus,
                                input logic bz, input logic [3:0] lvl);
        vec_t v;
        v.in_valid = iv; v.in_data = d; v.gnt = g;
        v.exp_req = rq; v.exp_bv = bv; v.exp_bus = bus; v.exp_busy = bz; v.exp_level = lvl;
        return v;
    endfunction

    task automatic push_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            @(negedge clkA);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_req();
        int guard = 0;
        while (reqA !== 1'b1 && guard < 64) begin
            @(negedge clkA);
            guard++;
        end
        check("req_rise_wait", reqA, 1'b1);
    endtask

    // Grant once, count bus words until reqA drops, then check the RELEASE cycle.
    task automatic grant_burst(output int n);
        int guard = 0;
        n = 0;
        wait_req();
        gntA = 1'b1;
        @(negedge clkA);
        gntA = 1'b0;
        while (reqA === 1'b1 && guard < 40) begin
            @(negedge clkA);
            guard++;
            if (bus_valid === 1'b1) n++;
        end
        check("release_reqA", reqA, 1'b0);
        check("release_busy", busy, 1'b1);
        check("release_bus_valid", bus_valid, 1'b0);
    endtask

    vec_t vecs[17];
    int   nb;
    int   cnt;
    int   pops;
    int   guard;
    logic acc;
    logic [DW-1:0] seq;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        gntA     = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_reqA", reqA, 1'b0);
        check("rst_bus_valid", bus_valid, 1'b0);
        check("rst_sharedBus", sharedBus, 64'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_level", fifo_level, 4'd0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clkA);
        reset = 1'b1;
        @(negedge clkA);

        // Single word, grant 11 cycles after reqA rises.
        vecs[0] = mk(1'b1, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 4'd1);
        vecs[1] = mk(1'b0, 64'h0,         1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 4'd1);
        for (int i = 2; i < 12; i++)
            vecs[i] = mk(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 4'd1);
        vecs[12] = mk(1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 4'd1);
        vecs[13] = mk(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 64'hDEAD_BEEF, 1'b1, 4'd0);
        vecs[14] = mk(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,         1'b1, 4'd0);
        vecs[15] = mk(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,         1'b0, 4'd0);
        vecs[16] = mk(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0,         1'b0, 4'd0);
        for (int i = 0; i < 17; i++) begin
            in_valid = vecs[i].in_valid;
            in_data  = vecs[i].in_data;
            gntA     = vecs[i].gnt;
            @(negedge clkA);
            check($sformatf("vec%0d_reqA", i), reqA, vecs[i].exp_req);
            check($sformatf("vec%0d_bus_valid", i), bus_valid, vecs[i].exp_bv);
            check($sformatf("vec%0d_sharedBus", i), sharedBus, vecs[i].exp_bus);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
            check($sformatf("vec%0d_timeout_err", i), timeout_err, 1'b0);
        end
        in_valid = 1'b0;
        gntA     = 1'b0;

        // Six words split into a full burst and a remainder burst.
        push_words(6, 64'h3000_0000);
        grant_burst(nb);
        check("burst1_len", nb, 4);
        grant_burst(nb);
        check("burst2_len", nb, 2);
        @(negedge clkA);
        check("after_bursts_level", fifo_level, 4'd0);

        // Fill to full; extra push ignored; push alongside pop holds level.
        push_words(8, 64'h4000_0000);
        check("full_level", fifo_level, 4'd8);
        check("full_in_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        in_data  = 64'hBAD0_BAD0;
        @(negedge clkA);
        in_valid = 1'b0;
        check("ninth_push_ignored", fifo_level, 4'd8);
        wait_req();
        gntA = 1'b1;
        @(negedge clkA);
        gntA  = 1'b0;
        seq   = 64'h5000_0000;
        pops  = 0;
        guard = 0;
        while (reqA === 1'b1 && guard < 40) begin
            in_valid = 1'b1;
            in_data  = seq;
            acc      = in_ready;
            @(negedge clkA);
            guard++;
            if (acc) seq++;
            if (bus_valid === 1'b1) begin
                pops++;
                check("pop_level", fifo_level, 4'd7);
            end
        end
        in_valid = 1'b0;
        check("full_burst_len", pops, 4);
        check("refill_level", fifo_level, 4'd8);
        grant_burst(nb);
        check("drain1_len", nb, 4);
        grant_burst(nb);
        check("drain2_len", nb, 4);

        // Grant timeout: 32 REQ cycles, pulse, RELEASE, IDLE, REQ again.
        push_words(1, 64'h6000_CAFE);
        wait_req();
        cnt = 0;
        while (reqA === 1'b1 && cnt < 100) begin
            cnt++;
            check("req_no_error", timeout_err, 1'b0);
            @(negedge clkA);
        end
        check("timeout_req_cycles", cnt, 32);
        check("timeout_pulse", timeout_err, 1'b1);
        check("timeout_busy", busy, 1'b1);
        @(negedge clkA);
        check("timeout_pulse_end", timeout_err, 1'b0);
        check("timeout_idle_busy", busy, 1'b0);
        check("timeout_idle_reqA", reqA, 1'b0);
        @(negedge clkA);
        check("timeout_re_req", reqA, 1'b1);

        // Grant on the timeout cycle wins.
        repeat (31) @(negedge clkA);
        gntA = 1'b1;
        @(negedge clkA);
        gntA = 1'b0;
        check("collide_no_error", timeout_err, 1'b0);
        check("collide_reqA", reqA, 1'b1);
        @(negedge clkA);
        check("collide_bus_valid", bus_valid, 1'b1);
        @(negedge clkA);
        check("collide_release_reqA", reqA, 1'b0);
        check("collide_release_err", timeout_err, 1'b0);
        @(negedge clkA);

        // Reset in the middle of a burst.
        push_words(4, 64'h7000_0000);
        wait_req();
        gntA = 1'b1;
        @(negedge clkA);
        gntA  = 1'b0;
        pops  = 0;
        guard = 0;
        while (pops < 2 && guard < 20) begin
            @(negedge clkA);
            guard++;
            if (bus_valid === 1'b1) pops++;
        end
        check("midrst_words_before", pops, 2);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_reqA", reqA, 1'b0);
        check("midrst_bus_valid", bus_valid, 1'b0);
        check("midrst_sharedBus", sharedBus, 64'h0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_timeout_err", timeout_err, 1'b0);
        check("midrst_level", fifo_level, 4'd0);
        @(negedge clkA);
        reset = 1'b1;
        @(negedge clkA);
        check("postrst_level", fifo_level, 4'd0);
        check("postrst_in_ready", in_ready, 1'b1);
        check("postrst_reqA", reqA, 1'b0);
        push_words(1, 64'h8000_0001);
        grant_burst(nb);
        check("postrst_burst_len", nb, 1);

        repeat (3) @(negedge clkA);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
